// File: rtl/afifo_rd_stream.sv
// Async-FIFO read-side consumer: pops the FIFO, absorbs its 1-cycle read latency and
// re-presents words on a valid/ready stream through a 2-entry skid buffer.
module afifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              rdclk,
    input  logic              rd_rst,
    input  logic              empty,
    output logic              pop,
    input  logic [DATA_W-1:0] data_out,
    input  logic              enable,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              busy
);

    logic [1:0]        r_occ;
    logic              r_infl;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_xfer;
    logic [1:0]        w_level;
    logic [1:0]        w_occ_nxt;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_skid_nxt;

    assign m_valid  = (r_occ != 2'd0);
    assign m_data   = r_head;
    assign word_cnt = r_cnt;
    assign busy     = (r_occ != 2'd0) | r_infl;
    assign w_xfer   = m_valid & m_ready;

    // Occupancy after this cycle's capture and transfer; pop only if a slot remains for
    // the word it will return next cycle. The m_ready -> pop path is deliberate.
    assign w_level = r_occ + {1'b0, r_infl} - {1'b0, w_xfer};
    assign pop     = ~rd_rst & enable & ~empty & (w_level < 2'd2);

    always_comb begin
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        w_occ_nxt  = (w_level > 2'd2) ? 2'd2 : w_level;
        case (r_occ)
            2'd0: begin
                if (r_infl) w_head_nxt = data_out;
            end
            2'd1: begin
                if (w_xfer) begin
                    if (r_infl) w_head_nxt = data_out;
                end else if (r_infl) begin
                    w_skid_nxt = data_out;
                end
            end
            default: begin
                if (w_xfer) begin
                    w_head_nxt = r_skid;
                    if (r_infl) w_skid_nxt = data_out;
                end
            end
        endcase
    end

    always_ff @(posedge rdclk or posedge rd_rst) begin
        if (rd_rst) begin
            r_occ  <= 2'd0;
            r_infl <= 1'b0;
            r_head <= '0;
            r_skid <= '0;
            r_cnt  <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_infl <= pop;
            r_head <= w_head_nxt;
            r_skid <= w_skid_nxt;
            if (w_xfer) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
